// File: rtl/mct_rd_sched_pkg.sv
// mct_rd_sched_pkg: shared state encoding and constants for the MCT read scheduler
package mct_rd_sched_pkg;
  typedef enum logic [2:0] {S_IDLE, S_NFA, S_QRY, S_DRAIN, S_DONE} sched_state_t;
  localparam int LP_BEAT_BYTES = 64;
  localparam int LP_4K_BEATS = 64;
  localparam logic STYPE_NFA = 1'b0;
  localparam logic STYPE_QUERY = 1'b1;
endpackage

// File: rtl/mct_rd_burst_gen.sv
// mct_rd_burst_gen: per-region address/remaining pair with 4 KB-safe burst length
module mct_rd_burst_gen #(
  parameter int AW = 64,
  parameter int BW = 26,
  parameter int MAXB = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          adv,
  input  logic [AW-1:0] load_addr,
  input  logic [BW-1:0] load_beats,
  output logic [AW-1:0] addr,
  output logic [6:0]    len,
  output logic          last
);
  import mct_rd_sched_pkg::*;
  localparam int BS = $clog2(LP_BEAT_BYTES);
  logic [BW-1:0] left;
  logic [6:0] to_4k, cap;
  always_comb begin
    to_4k = 7'(LP_4K_BEATS) - {1'b0, addr[11:6]};
    cap = (to_4k < 7'(MAXB)) ? to_4k : 7'(MAXB);
    len = (left < BW'(cap)) ? left[6:0] : cap;
    last = left == BW'(len);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      addr <= '0;
      left <= '0;
    end else if (load) begin
      addr <= load_addr;
      left <= load_beats;
    end else if (adv) begin
      addr <= addr + (AW'(len) << BS);
      left <= left - BW'(len);
    end
endmodule

// File: rtl/mct_rd_scheduler.sv
// mct_rd_scheduler: AR burst sequencer (NFA then query) with beat tagging and done pulse
// SCHED_STATS_EN adds stat_ar_stall_cycles / stat_bursts counters.
module mct_rd_scheduler #(
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_XFER_SIZE_WIDTH = 32,
  parameter int C_MAX_BURST_BEATS = 64,
  parameter int C_MAX_OUTSTANDING = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ctrl_start,
  output logic                          ctrl_done,
  output logic                          busy,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] nfa_ptr,
  input  logic [C_XFER_SIZE_WIDTH-1:0]  nfa_xfer_size_in_bytes,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] query_ptr,
  input  logic [C_XFER_SIZE_WIDTH-1:0]  query_xfer_size_in_bytes,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]                    m_axi_arlen,
  input  logic                          r_beat,
  input  logic                          r_last,
  output logic                          beat_ttype,
`ifdef SCHED_STATS_EN
  output logic                          beat_tlast,
  output logic [31:0]                   stat_ar_stall_cycles,
  output logic [31:0]                   stat_bursts
`else
  output logic                          beat_tlast
`endif
);
  import mct_rd_sched_pkg::*;
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int BW = C_XFER_SIZE_WIDTH - 6;
  localparam int OW = $clog2(C_MAX_OUTSTANDING + 1);
  sched_state_t state, state_nxt;
  logic [AW-1:0] qry_addr, gen_addr_in, gen_addr;
  logic [BW-1:0] qry_beats, gen_beats_in, nfa_bt, qry_bt;
  logic [BW-1:0] nfa_rx_left, qry_rx_left, nfa_rx_nxt, qry_rx_nxt;
  logic [OW-1:0] outstanding, out_nxt;
  logic [6:0] gen_len;
  logic gen_load, gen_last, issuing, ar_hs, rx_dec, nfa_act, start_ok, unused_ok;
  assign nfa_bt = nfa_xfer_size_in_bytes[C_XFER_SIZE_WIDTH-1:6];
  assign qry_bt = query_xfer_size_in_bytes[C_XFER_SIZE_WIDTH-1:6];
  assign unused_ok = ^{nfa_xfer_size_in_bytes[5:0], query_xfer_size_in_bytes[5:0]};
  assign start_ok = ctrl_start && state == S_IDLE;
  assign issuing = state == S_NFA || state == S_QRY;
  assign m_axi_arvalid = issuing && outstanding < OW'(C_MAX_OUTSTANDING);
  assign m_axi_araddr = gen_addr;
  assign m_axi_arlen = m_axi_arvalid ? 8'(gen_len - 7'd1) : 8'd0;
  assign ar_hs = m_axi_arvalid && m_axi_arready;
  assign rx_dec = r_beat && r_last && outstanding != '0;
  assign out_nxt = outstanding + OW'(ar_hs) - OW'(rx_dec);
  // In-order single-ID return: NFA beats always arrive before any query beat.
  assign nfa_act = nfa_rx_left != '0;
  assign nfa_rx_nxt = (r_beat && nfa_act) ? nfa_rx_left - BW'(1) : nfa_rx_left;
  assign qry_rx_nxt = (r_beat && !nfa_act && qry_rx_left != '0) ? qry_rx_left - BW'(1) : qry_rx_left;
  assign busy = state != S_IDLE;
  assign ctrl_done = state == S_DONE;
  assign beat_ttype = (busy && !nfa_act) ? STYPE_QUERY : STYPE_NFA;
  assign beat_tlast = (nfa_act ? nfa_rx_left : qry_rx_left) == BW'(1);
  always_comb begin
    state_nxt = state;
    gen_load = 1'b0;
    gen_addr_in = qry_addr;
    gen_beats_in = qry_beats;
    unique case (state)
      S_IDLE: if (ctrl_start) begin
        gen_load = 1'b1;
        gen_addr_in = nfa_bt != '0 ? nfa_ptr : query_ptr;
        gen_beats_in = nfa_bt != '0 ? nfa_bt : qry_bt;
        state_nxt = nfa_bt != '0 ? S_NFA : qry_bt != '0 ? S_QRY : S_DRAIN;
      end
      S_NFA: if (ar_hs && gen_last) begin
        gen_load = 1'b1;
        state_nxt = qry_beats != '0 ? S_QRY : S_DRAIN;
      end
      S_QRY: if (ar_hs && gen_last) state_nxt = S_DRAIN;
      S_DRAIN: if (out_nxt == '0 && nfa_rx_nxt == '0 && qry_rx_nxt == '0) state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_IDLE;
      qry_addr <= '0;
      qry_beats <= '0;
      nfa_rx_left <= '0;
      qry_rx_left <= '0;
      outstanding <= '0;
    end else begin
      state <= state_nxt;
      outstanding <= out_nxt;
      nfa_rx_left <= start_ok ? nfa_bt : nfa_rx_nxt;
      qry_rx_left <= start_ok ? qry_bt : qry_rx_nxt;
      if (start_ok) begin
        qry_addr <= query_ptr;
        qry_beats <= qry_bt;
      end
    end
  mct_rd_burst_gen #(.AW(AW), .BW(BW), .MAXB(C_MAX_BURST_BEATS)) u_gen (
    .clk(clk),
    .rst(rst),
    .load(gen_load),
    .adv(ar_hs),
    .load_addr(gen_addr_in),
    .load_beats(gen_beats_in),
    .addr(gen_addr),
    .len(gen_len),
    .last(gen_last)
  );
`ifdef SCHED_STATS_EN
  logic stall;
  assign stall = (m_axi_arvalid && !m_axi_arready) || (issuing && !m_axi_arvalid);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      stat_ar_stall_cycles <= '0;
      stat_bursts <= '0;
    end else if (start_ok) begin
      stat_ar_stall_cycles <= '0;
      stat_bursts <= '0;
    end else begin
      if (stall && !(&stat_ar_stall_cycles)) stat_ar_stall_cycles <= stat_ar_stall_cycles + 32'd1;
      if (ar_hs && !(&stat_bursts)) stat_bursts <= stat_bursts + 32'd1;
    end
`endif
endmodule

// File: tb/tb_mct_rd_scheduler.sv
// tb_mct_rd_scheduler: directed checks of burst splitting, outstanding limit, tagging and done
module tb_mct_rd_scheduler;
  logic clk = 1'b0;
  logic rst, ctrl_start, ctrl_done, busy;
  logic [63:0] nfa_ptr, query_ptr, m_axi_araddr;
  logic [31:0] nfa_sz, query_sz;
  logic m_axi_arvalid, m_axi_arready, r_beat, r_last, beat_ttype, beat_tlast;
  logic [7:0] m_axi_arlen;
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mct_rd_scheduler #(.C_MAX_OUTSTANDING(2)) dut (
    .clk(clk),
    .rst(rst),
    .ctrl_start(ctrl_start),
    .ctrl_done(ctrl_done),
    .busy(busy),
    .nfa_ptr(nfa_ptr),
    .nfa_xfer_size_in_bytes(nfa_sz),
    .query_ptr(query_ptr),
    .query_xfer_size_in_bytes(query_sz),
    .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready),
    .m_axi_araddr(m_axi_araddr),
    .m_axi_arlen(m_axi_arlen),
    .r_beat(r_beat),
    .r_last(r_last),
    .beat_ttype(beat_ttype),
    .beat_tlast(beat_tlast)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ar(input string tag, input logic [63:0] a, input logic [7:0] l);
    chk({tag, "_vld"}, m_axi_arvalid, 1);
    chk({tag, "_addr"}, m_axi_araddr, a);
    chk({tag, "_len"}, m_axi_arlen, l);
    cyc();
  endtask

  task automatic beats(input string tag, input int n, input logic tt, input int tl);
    for (int i = 0; i < n; i++) begin
      r_beat = 1'b1;
      r_last = (i == n - 1);
      chk($sformatf("%s_ttype%0d", tag, i), beat_ttype, tt);
      chk($sformatf("%s_tlast%0d", tag, i), beat_tlast, i == tl);
      cyc();
    end
    r_beat = 1'b0;
    r_last = 1'b0;
  endtask

  task automatic start();
    ctrl_start = 1'b1;
    cyc();
    ctrl_start = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    ctrl_start = 1'b0;
    nfa_ptr = '0;
    query_ptr = '0;
    nfa_sz = '0;
    query_sz = '0;
    m_axi_arready = 1'b1;
    r_beat = 1'b0;
    r_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_arvalid", m_axi_arvalid, 0);
    chk("rst_araddr", m_axi_araddr, 0);
    chk("rst_arlen", m_axi_arlen, 0);
    chk("rst_done", ctrl_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ttype", beat_ttype, 0);
    chk("rst_tlast", beat_tlast, 0);
    rst = 1'b0;
    cyc();

    // 8 KB NFA + 128 B query, two bursts allowed in flight
    nfa_ptr = 64'h1000; nfa_sz = 32'd8192;
    query_ptr = 64'h8000; query_sz = 32'd128;
    start();
    chk("t1_busy", busy, 1);
    ar("t1_ar0", 64'h1000, 8'd63);
    ar("t1_ar1", 64'h2000, 8'd63);
    chk("t1_limit", m_axi_arvalid, 0);
    beats("t1_b0", 64, 1'b0, -1);
    ar("t1_ar2", 64'h8000, 8'd1);
    chk("t1_drain_vld", m_axi_arvalid, 0);
    beats("t1_b1", 64, 1'b0, 63);
    beats("t1_b2", 2, 1'b1, 1);
    chk("t1_done", ctrl_done, 1);
    cyc();
    chk("t1_done_pulse", ctrl_done, 0);
    chk("t1_idle", busy, 0);

    // region starting one beat below a 4 KB boundary
    nfa_ptr = 64'h0FC0; nfa_sz = 32'd256;
    query_ptr = 64'h9000; query_sz = 32'd0;
    start();
    ar("t2_ar0", 64'h0FC0, 8'd0);
    ar("t2_ar1", 64'h1000, 8'd2);
    chk("t2_nomore", m_axi_arvalid, 0);
    chk("t2_busy", busy, 1);
    beats("t2_b0", 1, 1'b0, -1);
    beats("t2_b1", 3, 1'b0, 2);
    chk("t2_done", ctrl_done, 1);
    cyc();
    chk("t2_done_pulse", ctrl_done, 0);

    // both regions empty (only sub-beat size bits set)
    nfa_sz = 32'h3F; query_sz = 32'h3F;
    start();
    chk("t3_busy", busy, 1);
    chk("t3_done_early", ctrl_done, 0);
    chk("t3_novld0", m_axi_arvalid, 0);
    cyc();
    chk("t3_done", ctrl_done, 1);
    chk("t3_novld1", m_axi_arvalid, 0);
    cyc();
    chk("t3_done_pulse", ctrl_done, 0);
    chk("t3_idle", busy, 0);

    // stray rlast while idle must not disturb the outstanding count
    r_beat = 1'b1; r_last = 1'b1;
    cyc();
    r_beat = 1'b0; r_last = 1'b0;

    // arready held low, second start mid-transfer ignored
    nfa_ptr = 64'h10000; nfa_sz = 32'd4096;
    query_ptr = 64'h20000; query_sz = 32'd64;
    m_axi_arready = 1'b0;
    start();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t4_hold_vld%0d", k), m_axi_arvalid, 1);
      chk($sformatf("t4_hold_addr%0d", k), m_axi_araddr, 64'h10000);
      chk($sformatf("t4_hold_len%0d", k), m_axi_arlen, 63);
      ctrl_start = (k == 2);
      if (k == 2) begin
        nfa_ptr = 64'h30000; nfa_sz = 32'd128;
        query_ptr = 64'h50000; query_sz = 32'd4096;
      end
      cyc();
    end
    ctrl_start = 1'b0;
    m_axi_arready = 1'b1;
    ar("t4_ar0", 64'h10000, 8'd63);
    ar("t4_ar1", 64'h20000, 8'd0);
    chk("t4_nomore", m_axi_arvalid, 0);
    beats("t4_b0", 64, 1'b0, 63);
    beats("t4_b1", 1, 1'b1, 0);
    chk("t4_done", ctrl_done, 1);
    cyc();
    chk("t4_done_pulse", ctrl_done, 0);

    // asynchronous reset while a query AR is pending
    nfa_ptr = 64'h1000; nfa_sz = 32'd64;
    query_ptr = 64'h40000; query_sz = 32'd8192;
    start();
    ar("t5_ar0", 64'h1000, 8'd0);
    m_axi_arready = 1'b0;
    chk("t5_qry_vld", m_axi_arvalid, 1);
    chk("t5_qry_addr", m_axi_araddr, 64'h40000);
    rst = 1'b1;
    #1;
    chk("t5_rst_vld", m_axi_arvalid, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_len", m_axi_arlen, 0);
    cyc();
    rst = 1'b0;
    m_axi_arready = 1'b1;
    nfa_ptr = 64'h2000; nfa_sz = 32'd128;
    query_ptr = 64'h3000; query_sz = 32'd64;
    start();
    ar("t5_ar1", 64'h2000, 8'd1);
    ar("t5_ar2", 64'h3000, 8'd0);
    chk("t5_nomore", m_axi_arvalid, 0);
    beats("t5_b0", 2, 1'b0, 1);
    beats("t5_b1", 1, 1'b1, 0);
    chk("t5_done", ctrl_done, 1);
    cyc();
    chk("t5_done_pulse", ctrl_done, 0);
    chk("t5_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
